hdmi_tx_config_sequencer: RTL and testbench

Sequences the power-up and hot-plug register configuration of the HDMI transmitter over the shared I2C master. It walks a constant table of (register, value) byte writes and issues one write at a time to the I2C byte-write engine through a req/done handshake. It retries NACKed writes and re-runs the whole table when the transmitter raises its interrupt line. It sits between hdmi_generator's I2C engine and the transmitter interrupt pin, and it reports configuration status to the PPU and HPS side.

---
 rtl/hdmi_cfg_pkg.sv | 21 ++
 rtl/hdmi_tx_config_rom.sv | 55 +++++
 rtl/sync_2ff.sv | 26 ++
 rtl/hdmi_tx_config_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_hdmi_tx_config_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_cfg_pkg.sv
// Shared types and constants for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    S_WAIT,
    S_ISSUE,
    S_BUSY,
    S_CHECK,
    S_IDLE,
    S_ERROR
  } cfg_state_e;

  localparam logic [7:0] ADV_INT_CLR_REG = 8'h96;
  localparam logic [7:0] ADV_INT_CLR_VAL = 8'hF6;

endpackage

// File: rtl/hdmi_tx_config_rom.sv
// Transmitter register list: one (register, value) byte write per index.
module hdmi_tx_config_rom
  import hdmi_cfg_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] i_idx,
  output cfg_entry_t       o_entry
);

  logic [5:0] w_sel;

  assign w_sel = 6'(i_idx);

  always_comb begin
    o_entry = '{reg_addr: 8'h00, data: 8'h00};
    case (w_sel)
      6'd0:  o_entry = '{reg_addr: ADV_INT_CLR_REG, data: ADV_INT_CLR_VAL};
      6'd1:  o_entry = '{reg_addr: 8'h41, data: 8'h10};
      6'd2:  o_entry = '{reg_addr: 8'h98, data: 8'h03};
      6'd3:  o_entry = '{reg_addr: 8'h9A, data: 8'hE0};
      6'd4:  o_entry = '{reg_addr: 8'h9C, data: 8'h30};
      6'd5:  o_entry = '{reg_addr: 8'h9D, data: 8'h61};
      6'd6:  o_entry = '{reg_addr: 8'hA2, data: 8'hA4};
      6'd7:  o_entry = '{reg_addr: 8'hA3, data: 8'hA4};
      6'd8:  o_entry = '{reg_addr: 8'hE0, data: 8'hD0};
      6'd9:  o_entry = '{reg_addr: 8'hF9, data: 8'h00};
      6'd10: o_entry = '{reg_addr: 8'h15, data: 8'h00};
      6'd11: o_entry = '{reg_addr: 8'h16, data: 8'h30};
      6'd12: o_entry = '{reg_addr: 8'h17, data: 8'h02};
      6'd13: o_entry = '{reg_addr: 8'h18, data: 8'h46};
      6'd14: o_entry = '{reg_addr: 8'hAF, data: 8'h06};
      6'd15: o_entry = '{reg_addr: 8'hBA, data: 8'h60};
      6'd16: o_entry = '{reg_addr: 8'hD0, data: 8'h3C};
      6'd17: o_entry = '{reg_addr: 8'hD6, data: 8'hC0};
      6'd18: o_entry = '{reg_addr: 8'hDE, data: 8'h9C};
      6'd19: o_entry = '{reg_addr: 8'hE4, data: 8'h60};
      // Remaining entries set audio, video timing and infoframe defaults.
      6'd20: o_entry = '{reg_addr: 8'hFA, data: 8'h7D};
      6'd21: o_entry = '{reg_addr: 8'h55, data: 8'h10};
      6'd22: o_entry = '{reg_addr: 8'h56, data: 8'h08};
      6'd23: o_entry = '{reg_addr: 8'h3B, data: 8'h80};
      6'd24: o_entry = '{reg_addr: 8'h3C, data: 8'h00};
      6'd25: o_entry = '{reg_addr: 8'h40, data: 8'h80};
      6'd26: o_entry = '{reg_addr: 8'h4C, data: 8'h04};
      6'd27: o_entry = '{reg_addr: 8'h94, data: 8'hC0};
      6'd28: o_entry = '{reg_addr: 8'h95, data: 8'h00};
      6'd29: o_entry = '{reg_addr: 8'h0A, data: 8'h01};
      6'd30: o_entry = '{reg_addr: 8'h0C, data: 8'h00};
      6'd31: o_entry = '{reg_addr: 8'hD5, data: 8'h00};
      default: o_entry = '{reg_addr: 8'h00, data: 8'h00};
    endcase
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer cell for asynchronous single-bit inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same edge,
      // giving a true two-stage shift; blocking would collapse them into one.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hdmi_tx_config_sequencer.sv
// Walks the transmitter register table over the shared I2C byte-write engine,
// retrying NACKed writes and re-running the table on transmitter interrupts.
module hdmi_tx_config_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = 8'h72,
  parameter int         NUM_ENTRIES    = 32,
  parameter int         STARTUP_CYCLES = 200000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hdmi_tx_int,
  output logic       i2c_req,
  output logic [7:0] i2c_dev,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_data,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       config_busy,
  output logic       config_done,
  output logic       config_error
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES - 1);

  cfg_state_e       r_state, w_state_n;
  logic [IDX_W-1:0] r_idx, w_idx_n;
  logic [RTY_W-1:0] r_retry, w_retry_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_int_pending, w_int_pending_n;
  logic             r_nack, w_nack_n;
  logic             r_req, w_req_n;
  logic [7:0]       r_reg, w_reg_n;
  logic [7:0]       r_data, w_data_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_error, w_error_n;

  logic             w_int_sync;
  logic             r_int_d;
  logic             w_int_rise;
  logic             w_restart;
  cfg_entry_t       w_entry;

  sync_2ff u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (hdmi_tx_int),
    .o_q   (w_int_sync)
  );

  hdmi_tx_config_rom #(.IDX_W(IDX_W)) u_rom (
    .i_idx   (r_idx),
    .o_entry (w_entry)
  );

  assign w_int_rise = w_int_sync & ~r_int_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_n       = r_state;
    w_idx_n         = r_idx;
    w_retry_n       = r_retry;
    w_cnt_n         = r_cnt;
    w_int_pending_n = r_int_pending;
    w_nack_n        = r_nack;
    w_req_n         = r_req;
    w_reg_n         = r_reg;
    w_data_n        = r_data;
    w_busy_n        = r_busy;
    w_done_n        = r_done;
    w_error_n       = r_error;
    w_restart       = 1'b0;

    if (w_int_rise && (r_state inside {S_WAIT, S_ISSUE, S_BUSY, S_CHECK})) begin
      w_int_pending_n = 1'b1;
    end

    case (r_state)
      S_WAIT: begin
        if (r_cnt == CNT_LAST) w_state_n = S_ISSUE;
        else                   w_cnt_n   = r_cnt + 1'b1;
      end
      S_ISSUE: begin
        w_reg_n   = w_entry.reg_addr;
        w_data_n  = w_entry.data;
        w_req_n   = 1'b1;
        w_state_n = S_BUSY;
      end
      S_BUSY: begin
        if (i2c_done) begin
          w_req_n   = 1'b0;
          w_nack_n  = i2c_nack;
          w_state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        // A walk that ends with an interrupt seen (pending or this cycle) chains
        // straight into the next walk instead of reporting a result.
        if (!r_nack && (r_idx != LAST_IDX)) begin
          w_idx_n   = r_idx + 1'b1;
          w_retry_n = '0;
          w_state_n = S_ISSUE;
        end else if (r_nack && (r_retry != RTY_MAX)) begin
          w_retry_n = r_retry + 1'b1;
          w_state_n = S_ISSUE;
        end else if (r_int_pending || w_int_rise) begin
          w_restart = 1'b1;
        end else if (!r_nack) begin
          w_state_n = S_IDLE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_state_n = S_ERROR;
          w_busy_n  = 1'b0;
          w_error_n = 1'b1;
        end
      end
      S_IDLE, S_ERROR: begin
        if (w_int_rise) w_restart = 1'b1;
      end
      default: w_state_n = S_WAIT;
    endcase

    if (w_restart) begin
      w_state_n       = S_ISSUE;
      w_idx_n         = '0;
      w_retry_n       = '0;
      w_int_pending_n = 1'b0;
      w_busy_n        = 1'b1;
      w_done_n        = 1'b0;
      w_error_n       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_WAIT;
      r_idx         <= '0;
      r_retry       <= '0;
      r_cnt         <= '0;
      r_int_pending <= 1'b0;
      r_nack        <= 1'b0;
      r_req         <= 1'b0;
      r_reg         <= 8'h00;
      r_data        <= 8'h00;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_int_d       <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_retry       <= w_retry_n;
      r_cnt         <= w_cnt_n;
      r_int_pending <= w_int_pending_n;
      r_nack        <= w_nack_n;
      r_req         <= w_req_n;
      r_reg         <= w_reg_n;
      r_data        <= w_data_n;
      r_busy        <= w_busy_n;
      r_done        <= w_done_n;
      r_error       <= w_error_n;
      r_int_d       <= w_int_sync;
    end
  end

  assign i2c_req      = r_req;
  assign i2c_dev      = DEV_ADDR;
  assign i2c_reg      = r_reg;
  assign i2c_data     = r_data;
  assign config_busy  = r_busy;
  assign config_done  = r_done;
  assign config_error = r_error;

endmodule

// File: tb/tb_hdmi_tx_config_sequencer.sv
// Scoreboard bench: expected writes are queued as each scenario is set up and
// popped by the I2C engine model whenever the sequencer raises a new request.
module tb_hdmi_tx_config_sequencer;

  localparam int         STARTUP = 10;
  localparam int         NENT    = 4;
  localparam int         MAXR    = 3;
  localparam logic [7:0] DEV     = 8'h72;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hdmi_tx_int = 1'b0;
  logic       i2c_done = 1'b0;
  logic       i2c_nack = 1'b0;
  logic       i2c_req;
  logic [7:0] i2c_dev, i2c_reg, i2c_data;
  logic       config_busy, config_done, config_error;

  always #5 clk = ~clk;

  hdmi_tx_config_sequencer #(
    .DEV_ADDR       (DEV),
    .NUM_ENTRIES    (NENT),
    .STARTUP_CYCLES (STARTUP),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hdmi_tx_int  (hdmi_tx_int),
    .i2c_req      (i2c_req),
    .i2c_dev      (i2c_dev),
    .i2c_reg      (i2c_reg),
    .i2c_data     (i2c_data),
    .i2c_done     (i2c_done),
    .i2c_nack     (i2c_nack),
    .config_busy  (config_busy),
    .config_done  (config_done),
    .config_error (config_error)
  );

  // Expected {reg, data} of the first four transmitter table entries.
  logic [15:0] tbl [NENT] = '{16'h96F6, 16'h4110, 16'h9803, 16'h9AE0};

  logic [15:0] sb_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  int          n_req = 0;
  bit          m_active = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_fields = '0;
  logic [7:0]  nack_reg = 8'h00;
  int          nack_left = 0;   // -1 = NACK forever

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_entry(input int i);
    sb_q.push_back(tbl[i]);
  endtask

  task automatic push_walk();
    for (int i = 0; i < NENT; i++) push_entry(i);
  endtask

  // I2C byte-write engine: done (with optional NACK) on the 5th cycle of a request.
  initial begin
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!rst_n) begin
        m_active = 1'b0;
      end else if (i2c_req) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_cnt    = 0;
          n_req++;
          m_fields = {i2c_reg, i2c_data};
          check("dev_addr", {24'h0, i2c_dev}, {24'h0, DEV});
          if (sb_q.size() == 0) check("sb_unexpected_req", sb_q.size(), 1);
          else                  check("sb_xfer", {16'h0, m_fields}, {16'h0, sb_q.pop_front()});
        end else begin
          m_cnt++;
        end
        if (m_cnt == 4) begin
          check("fields_held", {16'h0, i2c_reg, i2c_data}, {16'h0, m_fields});
          i2c_done = 1'b1;
          if (i2c_reg == nack_reg && nack_left != 0) begin
            i2c_nack = 1'b1;
            if (nack_left > 0) nack_left--;
          end
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic pulse_int(input int n);
    hdmi_tx_int = 1'b1;
    repeat (n) @(negedge clk);
    hdmi_tx_int = 1'b0;
  endtask

  task automatic measure_startup(input string tag);
    int k;
    for (k = 0; k < STARTUP + 20; k++) begin
      @(posedge clk);
      #1;
      if (i2c_req) break;
    end
    check(tag, k, STARTUP);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    repeat (5) @(negedge clk);
    for (k = 0; k < 3000 && config_busy; k++) @(negedge clk);
    check({tag, "_timeout"}, config_busy, 0);
  endtask

  task automatic wait_req_reg(input string tag, input logic [7:0] r);
    int k;
    for (k = 0; k < 500 && !(i2c_req && i2c_reg == r); k++) @(negedge clk);
    check(tag, (i2c_req && i2c_reg == r), 1);
  endtask

  initial begin
    int k;
    int n0;
    bit dropped;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req",   i2c_req,      0);
    check("rst_dev",   i2c_dev,      DEV);
    check("rst_reg",   i2c_reg,      0);
    check("rst_data",  i2c_data,     0);
    check("rst_busy",  config_busy,  1);
    check("rst_done",  config_done,  0);
    check("rst_error", config_error, 0);

    // Power-up walk after the startup delay
    push_walk();
    rst_n = 1'b1;
    measure_startup("startup_delay");
    wait_idle("walk1");
    check("walk1_done",  config_done,  1);
    check("walk1_error", config_error, 0);
    check("walk1_sb",    sb_q.size(),  0);

    // Interrupt in idle: immediate restart, done drops
    @(negedge clk);
    push_walk();
    hdmi_tx_int = 1'b1;
    for (k = 0; k < STARTUP + 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) hdmi_tx_int = 1'b0;
      if (i2c_req) break;
    end
    hdmi_tx_int = 1'b0;
    check("int_no_startup", (k < STARTUP), 1);
    check("int_done_drop",  config_done, 0);
    check("int_busy",       config_busy, 1);
    wait_idle("int_walk");
    check("int_walk_done", config_done, 1);
    check("int_walk_sb",   sb_q.size(), 0);

    // Entry 2 NACKed twice, then ACKed
    nack_reg  = tbl[2][15:8];
    nack_left = 2;
    push_entry(0); push_entry(1);
    push_entry(2); push_entry(2); push_entry(2);
    push_entry(3);
    pulse_int(3);
    wait_idle("retry_walk");
    check("retry_done",  config_done,  1);
    check("retry_error", config_error, 0);
    check("retry_sb",    sb_q.size(),  0);
    check("retry_nacks", nack_left,    0);

    // Entry 1 always NACKed: 1 + MAX_RETRY issues, then error
    nack_reg  = tbl[1][15:8];
    nack_left = -1;
    push_entry(0);
    for (int i = 0; i <= MAXR; i++) push_entry(1);
    pulse_int(3);
    wait_idle("err_walk");
    check("err_error", config_error, 1);
    check("err_done",  config_done,  0);
    n0 = n_req;
    repeat (50) @(negedge clk);
    check("err_no_req", n_req,       n0);
    check("err_sb",     sb_q.size(), 0);

    // Interrupt during entry 1: current walk finishes, exactly one more walk
    nack_left = 0;
    push_walk();
    push_walk();
    pulse_int(3);
    check("err_cleared", config_error, 0);
    wait_req_reg("pend_entry1", tbl[1][15:8]);
    pulse_int(3);
    dropped = 1'b0;
    for (k = 0; k < 3000 && (sb_q.size() != 0 || config_busy); k++) begin
      @(negedge clk);
      if (!config_busy && sb_q.size() != 0) dropped = 1'b1;
    end
    check("pend_timeout",   config_busy,  0);
    check("pend_busy_held", dropped,      0);
    check("pend_done",      config_done,  1);
    check("pend_error",     config_error, 0);
    n0 = n_req;
    repeat (40) @(negedge clk);
    check("pend_no_extra", n_req, n0);

    // Reset while entry 2 is in flight
    push_entry(0); push_entry(1); push_entry(2);
    pulse_int(3);
    wait_req_reg("rst_entry2", tbl[2][15:8]);
    rst_n = 1'b0;
    #1;
    check("midrst_req",  i2c_req,     0);
    check("midrst_busy", config_busy, 1);
    check("midrst_reg",  i2c_reg,     0);
    repeat (2) @(negedge clk);
    push_walk();
    rst_n = 1'b1;
    measure_startup("midrst_startup");
    wait_idle("midrst_walk");
    check("midrst_done", config_done, 1);
    check("midrst_sb",   sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
